core_ex_alu_mc: RTL and testbench
=================================

Name: core_ex_alu_mc

Overview:
- Parametrised, multi-cycle successor to the EX-stage integer ALU.
- Executes all single-cycle RV32I ALU ops combinationally at width XLEN.
- Adds RV M-extension multiply/divide/remainder ops through an iterative radix-2^RADIX_BITS datapath, with a stall handshake towards the EX pipeline control.
- Sits in the EX stage between operand muxes and EX/MEM register.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- RADIX_BITS, 1, quotient/multiplier bits retired per cycle; one of 1, 2, 4; must divide XLEN.

Ports:
- clk  input  1  clock
- rest  input  1  asynchronous active-high reset
- op  input  5  ALU operation, `ALU_OP_* encoding
- op_wait_handle  input  1  EX stage holds a valid instruction for this unit
- op_accept  input  1  EX stage advances this cycle (instruction consumed)
- kill  input  1  flush; abort any multi-cycle op
- in1  input  XLEN  operand 1
- in2  input  XLEN  operand 2
- op_ready  output  1  out is valid this cycle
- out  output  XLEN  result

Behaviour:
- Op classes:
  - Combinational (C): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, NOT_AND; unknown op gives out=in1.
  - Multi-cycle (M): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Shift amount is in2[$clog2(XLEN)-1:0]; SRA sign-fills from in1[XLEN-1].
- C ops: out combinational from inputs; op_ready=1 in IDLE regardless of op_wait_handle.
- FSM states:
  - IDLE: on op_wait_handle=1 with an M op, latch op/in1/in2. Go to SPEC if special-case, else CALC with cnt=XLEN/RADIX_BITS.
  - CALC: retire RADIX_BITS per cycle, cnt--. On cnt==1 go to DONE.
  - SPEC: one cycle, then DONE.
  - DONE: result register drives out, op_ready=1. Hold until op_accept=1, then go to IDLE.
- op_ready=0 in IDLE when an M request is present, and in CALC/SPEC.
- Latency, measured from the request cycle:
  - op_ready is low for XLEN/RADIX_BITS+1 cycles (33 at 32/1, 9 at 32/4).
  - Special cases: low for 2 cycles.
- Latency is data-independent: no early-out on zero operands.
- Arithmetic: operands are converted to magnitudes per signedness (MULHSU: in1 signed, in2 unsigned). Unsigned iteration uses a 2*XLEN product/remainder register. Final negation:
  - product: sign = s1^s2.
  - quotient: sign = s1^s2.
  - remainder: takes the sign of the dividend.
- MUL returns low XLEN bits; MULH* return high XLEN bits.
- Special cases:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give in1.
  - Signed overflow (in1=100..0, in2=all ones, DIV/REM): quotient = in1, remainder = 0.
- kill: any state goes to IDLE next edge and the result register is invalidated. kill has priority over op_accept and over a new request in the same cycle.
- op_accept in IDLE or CALC is ignored. Inputs are not re-sampled in CALC/DONE.
- Simultaneous op_accept in DONE with a new M request: return to IDLE. The new request is taken the following cycle, so no result is reused.
- Reset:
  - state=IDLE, cnt=0, latched operands and result register = 0.
  - op_ready and out then follow IDLE rules.
  - Reset mid-CALC discards the operation.

Decomposition:
- core_define additions:
  - ALU_OP_MUL..ALU_OP_REMU codes, distinct from existing ALU_OP_* codes.
  - alu_state_t enum {IDLE, CALC, SPEC, DONE}.
  - is_md_op(op) function.
- Sub-module core_ex_alu_md_iter:
  - Contents: sign handling, 2*XLEN accumulator, RADIX_BITS-step shift-add/restoring-subtract unit, cnt.
  - Interface: start, kill, busy, done, result.
- Top holds the C-op mux, special-case detection and the FSM.

Test Plan:
- ADD in1=5, in2=7, op_wait_handle=1 -> out=12, op_ready=1 same cycle. SRA 0x80000000 by 4 -> 0xF8000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF (XLEN=32, RADIX_BITS=1) -> op_ready low 33 cycles, then out=0xFFFFFFFE. Repeat as MULH -> 0. Repeat as MUL -> 1.
- DIVU 100/0 -> out=0xFFFFFFFF after 2 cycles. REMU 100/0 -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM -> 0.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. Hold op_accept=0 for 5 cycles in DONE -> out stable, op_ready=1 throughout.
- kill on cycle 10 of MUL -> state IDLE next cycle. Then MUL 6x7 -> 42 after full latency. rest pulse mid-DIV -> IDLE, no spurious op_ready on the aborted op.
- RADIX_BITS=4, XLEN=64: MULHU 2^63 x 4 -> 2, op_ready low 17 cycles.

Source files
------------

// File: rtl/core_ex_alu_mc_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU: op codes, FSM states
// and op-class helpers.
package core_ex_alu_mc_pkg;

  localparam logic [4:0] ALU_OP_ADD     = 5'd0;
  localparam logic [4:0] ALU_OP_SUB     = 5'd1;
  localparam logic [4:0] ALU_OP_SLL     = 5'd2;
  localparam logic [4:0] ALU_OP_SLT     = 5'd3;
  localparam logic [4:0] ALU_OP_SLTU    = 5'd4;
  localparam logic [4:0] ALU_OP_XOR     = 5'd5;
  localparam logic [4:0] ALU_OP_SRL     = 5'd6;
  localparam logic [4:0] ALU_OP_SRA     = 5'd7;
  localparam logic [4:0] ALU_OP_OR      = 5'd8;
  localparam logic [4:0] ALU_OP_AND     = 5'd9;
  localparam logic [4:0] ALU_OP_NOT_AND = 5'd10;

  // M-extension ops occupy 16..23: bit 2 selects divide, bit 1 selects remainder
  localparam logic [4:0] ALU_OP_MUL     = 5'd16;
  localparam logic [4:0] ALU_OP_MULH    = 5'd17;
  localparam logic [4:0] ALU_OP_MULHSU  = 5'd18;
  localparam logic [4:0] ALU_OP_MULHU   = 5'd19;
  localparam logic [4:0] ALU_OP_DIV     = 5'd20;
  localparam logic [4:0] ALU_OP_DIVU    = 5'd21;
  localparam logic [4:0] ALU_OP_REM     = 5'd22;
  localparam logic [4:0] ALU_OP_REMU    = 5'd23;

  typedef enum logic [1:0] {IDLE, CALC, SPEC, DONE} alu_state_t;

  function automatic logic is_md_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/core_ex_alu_md_iter.sv
// Iterative multiply/divide engine: unsigned shift-add / restoring-subtract
// over a 2*XLEN accumulator, retiring RADIX_BITS bits per cycle.
module core_ex_alu_md_iter
  import core_ex_alu_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int STEPS = XLEN / RADIX_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0]   opnd, mag1, mag2, hi, lo, res_fin;
  logic [XLEN:0]     rem_sh, diff, sum;
  logic              s1, s2, is_div, is_rem, is_mulh, neg_res;

  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    case (op)
      ALU_OP_MUL, ALU_OP_MULH, ALU_OP_DIV, ALU_OP_REM: begin
        s1 = in1[XLEN-1];
        s2 = in2[XLEN-1];
      end
      ALU_OP_MULHSU: s1 = in1[XLEN-1];
      default: ;
    endcase
    mag1 = s1 ? -in1 : in1;
    mag2 = s2 ? -in2 : in2;
  end

  always_comb begin
    acc_nxt = acc;
    rem_sh  = '0;
    diff    = '0;
    sum     = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (is_div) begin
        rem_sh = acc_nxt[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opnd};
        if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc_nxt[XLEN-2:0], 1'b1};
        else             acc_nxt = {acc_nxt[2*XLEN-2:0], 1'b0};
      end else begin
        sum     = {1'b0, acc_nxt[2*XLEN-1:XLEN]} + (acc_nxt[0] ? {1'b0, opnd} : '0);
        acc_nxt = {sum, acc_nxt[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    hi   = acc_nxt[2*XLEN-1:XLEN];
    lo   = acc_nxt[XLEN-1:0];
    prod = neg_res ? -acc_nxt : acc_nxt;
    if (is_div) res_fin = is_rem ? (neg_res ? -hi : hi) : (neg_res ? -lo : lo);
    else        res_fin = is_mulh ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      busy    <= 1'b0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      is_rem  <= 1'b0;
      is_mulh <= 1'b0;
      neg_res <= 1'b0;
      result  <= '0;
    end else if (kill) begin
      cnt    <= '0;
      busy   <= 1'b0;
      result <= '0;
    end else if (start) begin
      cnt     <= CW'(STEPS);
      busy    <= 1'b1;
      acc     <= {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
      opnd    <= op[2] ? mag2 : mag1;
      is_div  <= op[2];
      is_rem  <= op[2] & op[1];
      is_mulh <= ~op[2] & (op[1:0] != 2'b00);
      // remainder follows the dividend, everything else follows s1^s2
      neg_res <= (op[2] & op[1]) ? s1 : (s1 ^ s2);
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy   <= 1'b0;
        result <= res_fin;
      end
    end
  end

  assign done = busy && (cnt == CW'(1));

endmodule

// File: rtl/core_ex_alu_mc.sv
// EX-stage ALU: combinational RV32I ops plus multi-cycle M-extension ops
// with a ready/accept stall handshake.
module core_ex_alu_mc
  import core_ex_alu_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            rest,
  input  logic [4:0]      op,
  input  logic            op_wait_handle,
  input  logic            op_accept,
  input  logic            kill,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            op_ready,
  output logic [XLEN-1:0] out
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_t      state, state_nxt;
  logic [4:0]      op_q;
  logic [XLEN-1:0] in1_q, in2_q, res_q, c_res, spec_res, md_result;
  logic [SHW-1:0]  shamt;
  logic            md_req, special, md_start, md_busy, md_done, spec_q, rem_q;

  assign shamt   = in2[SHW-1:0];
  assign md_req  = op_wait_handle && is_md_op(op);
  assign special = md_req && op[2] &&
                   ((in2 == '0) || (!op[0] && in1 == MIN_NEG && in2 == '1));

  always_comb begin
    case (op)
      ALU_OP_ADD:     c_res = in1 + in2;
      ALU_OP_SUB:     c_res = in1 - in2;
      ALU_OP_SLL:     c_res = in1 << shamt;
      ALU_OP_SLT:     c_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_OP_SLTU:    c_res = {{(XLEN-1){1'b0}}, in1 < in2};
      ALU_OP_XOR:     c_res = in1 ^ in2;
      ALU_OP_SRL:     c_res = in1 >> shamt;
      ALU_OP_SRA:     c_res = $signed(in1) >>> shamt;
      ALU_OP_OR:      c_res = in1 | in2;
      ALU_OP_AND:     c_res = in1 & in2;
      ALU_OP_NOT_AND: c_res = in1 & ~in2;
      default:        c_res = in1;
    endcase
  end

  // divide-by-zero is checked first; otherwise the latched op was a signed overflow
  always_comb begin
    rem_q = (op_q == ALU_OP_REM) || (op_q == ALU_OP_REMU);
    if (in2_q == '0) spec_res = rem_q ? in1_q : '1;
    else             spec_res = rem_q ? '0 : in1_q;
  end

  always_comb begin
    state_nxt = state;
    md_start  = 1'b0;
    op_ready  = 1'b0;
    out       = c_res;
    case (state)
      IDLE: begin
        op_ready = !md_req;
        if (!kill && md_req) begin
          state_nxt = special ? SPEC : CALC;
          md_start  = !special;
        end
      end
      CALC: begin
        if (kill || !md_busy) state_nxt = IDLE;
        else if (md_done)     state_nxt = DONE;
      end
      SPEC: state_nxt = kill ? IDLE : DONE;
      DONE: begin
        op_ready = 1'b1;
        out      = spec_q ? res_q : md_result;
        if (kill || op_accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state  <= IDLE;
      op_q   <= '0;
      in1_q  <= '0;
      in2_q  <= '0;
      res_q  <= '0;
      spec_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (kill) begin
        res_q  <= '0;
        spec_q <= 1'b0;
      end else if (state == IDLE && md_req) begin
        op_q   <= op;
        in1_q  <= in1;
        in2_q  <= in2;
        spec_q <= special;
      end else if (state == SPEC) begin
        res_q <= spec_res;
      end
    end
  end

  core_ex_alu_md_iter #(.XLEN(XLEN), .RADIX_BITS(RADIX_BITS)) u_md_iter (
    .clk    (clk),
    .rst    (rest),
    .start  (md_start),
    .kill   (kill),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_core_ex_alu_mc.sv
// Directed bench for core_ex_alu_mc at 32/1 and 64/4, with a queue of
// expected results and latencies consumed as each result appears.
module tb_core_ex_alu_mc;
  import core_ex_alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rest;
  logic [4:0]  op, op_b;
  logic        op_wait_handle, op_accept, kill;
  logic        owh_b, acc_b, kill_b;
  logic [31:0] in1, in2, out;
  logic [63:0] in1_b, in2_b, out_b;
  logic        op_ready, rdy_b;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  core_ex_alu_mc #(.XLEN(32), .RADIX_BITS(1)) dut (
    .clk(clk), .rest(rest), .op(op), .op_wait_handle(op_wait_handle),
    .op_accept(op_accept), .kill(kill), .in1(in1), .in2(in2),
    .op_ready(op_ready), .out(out)
  );

  core_ex_alu_mc #(.XLEN(64), .RADIX_BITS(4)) dut64 (
    .clk(clk), .rest(rest), .op(op_b), .op_wait_handle(owh_b),
    .op_accept(acc_b), .kill(kill_b), .in1(in1_b), .in2(in2_b),
    .op_ready(rdy_b), .out(out_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic c_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] want);
    @(negedge clk);
    op = o; in1 = a; in2 = b; op_wait_handle = 1'b1; op_accept = 1'b0;
    exp_q.push_back(64'(want));
    #1;
    chk({tag, " rdy"}, 64'(op_ready), 64'd1);
    chk(tag, 64'(out), exp_q.pop_front());
  endtask

  // counts low op_ready cycles starting with the current one, then checks result
  task automatic wait_done(input string tag, output logic [31:0] res);
    int n = 0;
    while (!op_ready && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, " lat"}, 64'(n), 64'(lat_q.pop_front()));
    res = out;
    chk(tag, 64'(out), exp_q.pop_front());
  endtask

  task automatic md_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want, input int lat,
                       input int hold);
    logic [31:0] r;
    @(negedge clk);
    op = o; in1 = a; in2 = b; op_wait_handle = 1'b1; op_accept = 1'b0;
    exp_q.push_back(64'(want));
    lat_q.push_back(lat);
    #1;
    wait_done(tag, r);
    op_wait_handle = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk({tag, " hold rdy"}, 64'(op_ready), 64'd1);
      chk({tag, " hold out"}, 64'(out), 64'(want));
    end
    @(negedge clk);
    op_accept = 1'b1;
    @(negedge clk);
    op_accept = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int n;
    rest = 1'b1;
    op = ALU_OP_ADD; in1 = '0; in2 = '0;
    op_wait_handle = 1'b0; op_accept = 1'b0; kill = 1'b0;
    op_b = ALU_OP_ADD; in1_b = '0; in2_b = '0;
    owh_b = 1'b0; acc_b = 1'b0; kill_b = 1'b0;
    #1;
    chk("reset rdy", 64'(op_ready), 64'd1);
    chk("reset out", 64'(out), 64'd0);
    repeat (2) @(negedge clk);
    rest = 1'b0;

    c_op("add",   ALU_OP_ADD,     32'd5,          32'd7,  32'd12);
    c_op("sra",   ALU_OP_SRA,     32'h8000_0000,  32'd4,  32'hF800_0000);
    c_op("srl",   ALU_OP_SRL,     32'h8000_0000,  32'd36, 32'h0800_0000);
    c_op("sub",   ALU_OP_SUB,     32'd3,          32'd5,  32'hFFFF_FFFE);
    c_op("slt",   ALU_OP_SLT,     32'hFFFF_FFFF,  32'd1,  32'd1);
    c_op("sltu",  ALU_OP_SLTU,    32'hFFFF_FFFF,  32'd1,  32'd0);
    c_op("andn",  ALU_OP_NOT_AND, 32'hFF00_FF00,  32'h0F0F_0F0F, 32'hF000_F000);
    c_op("unk",   5'd13,          32'h1234_5678,  32'd9,  32'h1234_5678);

    md_op("mulhu",  ALU_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    md_op("mulh",   ALU_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        33, 0);
    md_op("mul",    ALU_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        33, 0);
    md_op("mulhsu", ALU_OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 0);
    md_op("divu0",  ALU_OP_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 2, 0);
    md_op("remu0",  ALU_OP_REMU,   32'd100,       32'd0,         32'd100,       2, 0);
    md_op("divovf", ALU_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    md_op("removf", ALU_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, 0);
    md_op("divs",   ALU_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    md_op("rems",   ALU_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 5);
    md_op("divu",   ALU_OP_DIVU,   32'd100,       32'd7,         32'd14,        33, 0);
    md_op("remu",   ALU_OP_REMU,   32'd100,       32'd7,         32'd2,         33, 0);
    md_op("mulz",   ALU_OP_MUL,    32'd0,         32'd0,         32'd0,         33, 0);

    // accept in DONE together with a new request: the new op starts one cycle later
    @(negedge clk);
    op = ALU_OP_DIVU; in1 = 32'd100; in2 = 32'd0; op_wait_handle = 1'b1; op_accept = 1'b0;
    exp_q.push_back(64'hFFFF_FFFF);
    lat_q.push_back(2);
    #1;
    wait_done("chain1", r);
    op = ALU_OP_MUL; in1 = 32'd3; in2 = 32'd5; op_accept = 1'b1;
    @(negedge clk);
    op_accept = 1'b0;
    exp_q.push_back(64'd15);
    lat_q.push_back(33);
    #1;
    wait_done("chain2", r);
    op_wait_handle = 1'b0;
    @(negedge clk);
    op_accept = 1'b1;
    @(negedge clk);
    op_accept = 1'b0;

    // kill ten cycles into a multiply
    op = ALU_OP_MUL; in1 = 32'd6; in2 = 32'd7; op_wait_handle = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("kill busy", 64'(op_ready), 64'd0);
    kill = 1'b1; op_wait_handle = 1'b0; op = ALU_OP_ADD; in1 = 32'd3; in2 = 32'd4;
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("kill idle rdy", 64'(op_ready), 64'd1);
    chk("kill idle out", 64'(out), 64'd7);
    md_op("mul67", ALU_OP_MUL, 32'd6, 32'd7, 32'd42, 33, 0);

    // reset pulse in the middle of a divide
    @(negedge clk);
    op = ALU_OP_DIV; in1 = 32'd1000; in2 = 32'd7; op_wait_handle = 1'b1;
    repeat (5) @(negedge clk);
    rest = 1'b1; op_wait_handle = 1'b0; op = ALU_OP_ADD; in1 = 32'd1; in2 = 32'd2;
    #1;
    chk("rst mid rdy", 64'(op_ready), 64'd1);
    @(negedge clk);
    rest = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (op_ready !== 1'b1 || out !== 32'd3) n++;
    end
    chk("rst no spurious", 64'(n), 64'd0);

    // 64-bit, radix-16 instance
    @(negedge clk);
    op_b = ALU_OP_MULHU; in1_b = 64'h8000_0000_0000_0000; in2_b = 64'd4; owh_b = 1'b1;
    exp_q.push_back(64'd2);
    lat_q.push_back(17);
    #1;
    n = 0;
    while (!rdy_b && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mulhu64 lat", 64'(n), 64'(lat_q.pop_front()));
    chk("mulhu64", out_b, exp_q.pop_front());
    owh_b = 1'b0;
    @(negedge clk);
    acc_b = 1'b1;
    @(negedge clk);
    acc_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
